// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// The unit issues one-cycle-latency reads to the synchronous instruction
// memory from a word-addressed program counter. Returned words are queued in
// a small prefetch FIFO, and decode drains that FIFO over a valid/ready
// handshake. A redirect flushes the queue and refetches from a new target.
// Halt stops new issue but still lets the queue drain.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | out of reset, no fetching until start_i
// S_RUN   | issuing reads whenever the prefetch queue has room
// S_HALTED| issue stopped; in-flight beat and queue still drain

module fetch_unit #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  mem_en_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
);

    // Pointer width for the circular buffer and width of the occupancy counter.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_inflight;
    logic                  r_kill;

    logic [31:0]           r_data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] r_tag_q  [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [CW:0]           w_occ;
    logic                  w_issue;

    // Handshake and issue gating. The occupancy that matters for issue is
    // the queue fill plus the beat still in memory, minus whatever decode
    // takes this cycle. This keeps a slot reserved for every outstanding read.
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && instr_ready_i;
    assign w_push  = r_inflight && !r_kill && !redirect_i;
    assign w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_issue = (r_state == S_RUN) && !halt_i && !redirect_i
                     && (w_occ < (CW+1)'(DEPTH));

    // Control FSM: halt wins over start. A redirect does not change the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !halt_i) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (halt_i) r_state <= S_HALTED;
                end
                S_HALTED: begin
                    if (start_i && !halt_i) r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request side: program counter, registered memory request, in-flight flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc       <= RESET_PC;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_mem_en   <= w_issue;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_mem_addr <= r_pc;
                r_pc       <= r_pc + ADDR_WIDTH'(1);
            end
            if (redirect_i) begin
                r_pc <= redirect_pc_i;
            end
        end
    end

    // Kill marks a beat that will be in memory after a flush edge so its
    // response is dropped. Redirect also suppresses issue, so today this only
    // matters if that gate changes; the discard path stays independent of it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_kill <= 1'b0;
        end else if (redirect_i) begin
            r_kill <= w_issue;
        end else if (r_inflight) begin
            r_kill <= 1'b0;
        end
    end

    // Queue bookkeeping. A flush clears everything; a pop in the same cycle
    // is simply absorbed by the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage. It is only written while a read is outstanding, so a
    // floating bus is never captured. It needs no reset because the outputs
    // are gated by valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data_q[r_wr_ptr] <= mem_data_i;
            r_tag_q[r_wr_ptr]  <= r_mem_addr;
        end
    end

    assign mem_en_o      = r_mem_en;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wr_o      = 1'b0;
    assign mem_data_o    = 32'h0;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_data_q[r_rd_ptr] : 32'h0;
    assign instr_pc_o    = w_valid ? r_tag_q[r_rd_ptr]  : '0;

    // The issue rule reserves a slot for every read. A push into a full
    // queue without a matching pop would mean that bookkeeping is broken.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a stream-level model. The model expects delivered words to form a
// contiguous address sequence that restarts at each redirect target.

module tb_fetch_unit;

    localparam int AW = 11;
    localparam logic [AW-1:0] MASK = '1;

    logic          clk_i;
    logic          rst_ni;
    logic          start_i;
    logic          halt_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          mem_en_o;
    logic          mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [31:0]   mem_data_i;
    logic [31:0]   instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          instr_valid_o;
    logic          instr_ready_i;

    int            vectors = 0;
    int            miscompares = 0;
    logic [AW-1:0] exp_pc;

    fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(2), .RESET_PC(11'h000)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .halt_i       (halt_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_en_o     (mem_en_o),
        .mem_wr_o     (mem_wr_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return 32'hA000_0000 + {21'b0, a};
    endfunction

    // Synchronous memory: samples the request on the falling edge and holds
    // the word until the next falling edge. The bus floats while not enabled.
    always @(negedge clk_i) begin
        if (mem_en_o) mem_data_i = word(mem_addr_o);
        else          mem_data_i = 'z;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        start_i = 0; halt_i = 0; redirect_i = 0; redirect_pc_i = '0;
        instr_ready_i = 1;
        rst_ni = 1;
        #3 rst_ni = 0;
        #1;
        vectors++;
        if ({mem_en_o, mem_addr_o} !== {1'b0, 11'h000}) begin
            miscompares++;
            $display("FAIL reset_mem_req: got en=%0b addr=%h expected en=0 addr=000", mem_en_o, mem_addr_o);
        end
        vectors++;
        if ({instr_valid_o, instr_o, instr_pc_o} !== {1'b0, 32'h0, 11'h000}) begin
            miscompares++;
            $display("FAIL reset_instr: got v=%0b instr=%h pc=%h expected 0/0/0", instr_valid_o, instr_o, instr_pc_o);
        end
        vectors++;
        if ({mem_wr_o, mem_data_o} !== 33'h0) begin
            miscompares++;
            $display("FAIL reset_mem_wr: got wr=%0b data=%h expected 0/0", mem_wr_o, mem_data_o);
        end
        tick();
        tick();
        rst_ni = 1;
        tick();
        vectors++;
        if ({mem_en_o, instr_valid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_quiet: got en=%0b v=%0b expected 0/0", mem_en_o, instr_valid_o);
        end
    endtask

    // Start pulse with ready held: first word in the third cycle after start,
    // then one word per cycle.
    task automatic test_stream();
        instr_ready_i = 1;
        exp_pc = 11'h000;
        for (int i = 0; i <= 20; i++) begin
            start_i = (i == 0);
            @(negedge clk_i);
            if (i < 3) begin
                vectors++;
                if (instr_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_latency: cycle %0d got valid=%0b expected 0", i, instr_valid_o);
                end
            end else begin
                vectors++;
                if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL stream_data: cycle %0d got v=%0b pc=%h instr=%h expected pc=%h instr=%h",
                             i, instr_valid_o, instr_pc_o, instr_o, exp_pc, word(exp_pc));
                end
                exp_pc = exp_pc + 1'b1;
            end
            tick();
        end
        start_i = 0;
    endtask

    // Five stalled cycles: head held, issue stops; then the stream resumes
    // without a gap.
    task automatic test_backpressure();
        instr_ready_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            vectors++;
            if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got v=%0b pc=%h instr=%h expected pc=%h",
                         i, instr_valid_o, instr_pc_o, instr_o, exp_pc);
            end
            if (i >= 1) begin
                vectors++;
                if (mem_en_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_no_issue: cycle %0d got en=%0b expected 0", i, mem_en_o);
                end
            end
            tick();
        end
        instr_ready_i = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            vectors++;
            if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL stall_resume: cycle %0d got v=%0b pc=%h instr=%h expected pc=%h",
                         i, instr_valid_o, instr_pc_o, instr_o, exp_pc);
            end
            exp_pc = exp_pc + 1'b1;
            tick();
        end
    endtask

    // Redirect from full-rate streaming (a beat in flight), then from a
    // stalled, full queue.
    task automatic test_redirect();
        logic [AW-1:0] tgt;
        for (int s = 0; s < 2; s++) begin
            tgt = (s == 0) ? 11'h100 : 11'h200;
            if (s == 1) begin
                instr_ready_i = 0;
                tick();
                tick();
            end
            for (int k = 0; k <= 6; k++) begin
                redirect_i    = (k == 0);
                redirect_pc_i = tgt;
                instr_ready_i = (s == 0) || (k != 0);
                @(negedge clk_i);
                if (k == 0) begin
                    vectors++;
                    if (instr_valid_o !== 1'b1) begin
                        miscompares++;
                        $display("FAIL redir_pre: s=%0d got valid=%0b expected 1", s, instr_valid_o);
                    end
                end
                if (k == 1 || k == 2) begin
                    vectors++;
                    if (instr_valid_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL redir_flush: s=%0d k=%0d got valid=%0b pc=%h expected 0",
                                 s, k, instr_valid_o, instr_pc_o);
                    end
                end
                if (k == 2) begin
                    vectors++;
                    if ({mem_en_o, mem_addr_o} !== {1'b1, tgt}) begin
                        miscompares++;
                        $display("FAIL redir_issue: s=%0d got en=%0b addr=%h expected en=1 addr=%h",
                                 s, mem_en_o, mem_addr_o, tgt);
                    end
                end
                if (k >= 3) begin
                    exp_pc = tgt + AW'(k - 3);
                    vectors++;
                    if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                        miscompares++;
                        $display("FAIL redir_data: s=%0d k=%0d got v=%0b pc=%h instr=%h expected pc=%h instr=%h",
                                 s, k, instr_valid_o, instr_pc_o, instr_o, exp_pc, word(exp_pc));
                    end
                end
                tick();
            end
        end
        redirect_i = 0;
        instr_ready_i = 1;
    endtask

    // Address wrap from the top of memory back to zero.
    task automatic test_wrap();
        instr_ready_i = 1;
        for (int k = 0; k <= 6; k++) begin
            redirect_i    = (k == 0);
            redirect_pc_i = 11'h7FE;
            @(negedge clk_i);
            if (k == 4) begin
                vectors++;
                if ({mem_en_o, mem_addr_o} !== {1'b1, 11'h000}) begin
                    miscompares++;
                    $display("FAIL wrap_addr: got en=%0b addr=%h expected en=1 addr=000", mem_en_o, mem_addr_o);
                end
            end
            if (k >= 3) begin
                exp_pc = 11'h7FE + AW'(k - 3);
                vectors++;
                if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL wrap_data: k=%0d got v=%0b pc=%h instr=%h expected pc=%h instr=%h",
                             k, instr_valid_o, instr_pc_o, instr_o, exp_pc, word(exp_pc));
                end
            end
            tick();
        end
        redirect_i = 0;
    endtask

    // Halt while 0x010 is in memory: it is still delivered, issue stops, the
    // queue drains, and start resumes at 0x011.
    task automatic test_halt();
        instr_ready_i = 1;
        for (int k = 0; k <= 17; k++) begin
            redirect_i    = (k == 0);
            redirect_pc_i = 11'h00C;
            halt_i        = (k == 6);
            start_i       = (k == 13);
            @(negedge clk_i);
            if (k == 6) begin
                vectors++;
                if ({mem_en_o, mem_addr_o} !== {1'b1, 11'h010}) begin
                    miscompares++;
                    $display("FAIL halt_inflight: got en=%0b addr=%h expected en=1 addr=010", mem_en_o, mem_addr_o);
                end
            end
            if (k >= 3 && k <= 7) begin
                exp_pc = 11'h00C + AW'(k - 3);
                vectors++;
                if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL halt_deliver: k=%0d got v=%0b pc=%h instr=%h expected pc=%h",
                             k, instr_valid_o, instr_pc_o, instr_o, exp_pc);
                end
            end
            if (k >= 8 && k <= 14) begin
                vectors++;
                if (instr_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL halt_drained: k=%0d got valid=%0b pc=%h expected 0", k, instr_valid_o, instr_pc_o);
                end
            end
            if (k >= 7 && k <= 14) begin
                vectors++;
                if (mem_en_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL halt_no_issue: k=%0d got en=%0b addr=%h expected 0", k, mem_en_o, mem_addr_o);
                end
            end
            if (k == 15) begin
                vectors++;
                if ({mem_en_o, mem_addr_o} !== {1'b1, 11'h011}) begin
                    miscompares++;
                    $display("FAIL halt_resume_addr: got en=%0b addr=%h expected en=1 addr=011", mem_en_o, mem_addr_o);
                end
            end
            if (k >= 16) begin
                exp_pc = 11'h011 + AW'(k - 16);
                vectors++;
                if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL halt_resume_data: k=%0d got v=%0b pc=%h instr=%h expected pc=%h",
                             k, instr_valid_o, instr_pc_o, instr_o, exp_pc);
                end
            end
            tick();
        end
        redirect_i = 0; halt_i = 0; start_i = 0;
        exp_pc = 11'h013;
    endtask

    // Reset asserted mid-burst for one cycle, then a fresh start from RESET_PC.
    task automatic test_reset_mid();
        instr_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            vectors++;
            if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL rstmid_pre: i=%0d got v=%0b pc=%h instr=%h expected pc=%h",
                         i, instr_valid_o, instr_pc_o, instr_o, exp_pc);
            end
            exp_pc = exp_pc + 1'b1;
            tick();
        end
        #2 rst_ni = 0;
        #1;
        vectors++;
        if ({mem_en_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: got en=%0b addr=%h v=%0b instr=%h pc=%h expected all 0",
                     mem_en_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o);
        end
        tick();
        rst_ni = 1;
        exp_pc = 11'h000;
        for (int i = 0; i <= 6; i++) begin
            start_i = (i == 0);
            @(negedge clk_i);
            if (i < 3) begin
                vectors++;
                if (instr_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_latency: i=%0d got valid=%0b expected 0", i, instr_valid_o);
                end
            end else begin
                vectors++;
                if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL rstmid_restart: i=%0d got v=%0b pc=%h instr=%h expected pc=%h",
                             i, instr_valid_o, instr_pc_o, instr_o, exp_pc);
                end
                exp_pc = exp_pc + 1'b1;
            end
            tick();
        end
        start_i = 0;
    endtask

    // Random control traffic against a stream-level model. Delivered words
    // and issued addresses each follow a contiguous sequence restarted by
    // redirect. Issue is only legal one cycle after an un-halted,
    // un-redirected running cycle.
    task automatic test_random();
        int            m_state;
        logic [AW-1:0] m_issue_pc;
        logic          prev_issue_ok;
        logic          prev_hold;
        logic          prev_redirect;
        logic [AW-1:0] prev_pc;
        logic [31:0]   prev_instr;

        rst_ni = 0;
        start_i = 0; halt_i = 0; redirect_i = 0;
        tick();
        rst_ni = 1;
        m_state = 0;
        exp_pc = 11'h000;
        m_issue_pc = 11'h000;
        prev_issue_ok = 0; prev_hold = 0; prev_redirect = 0;
        prev_pc = '0; prev_instr = '0;

        for (int c = 0; c < 3000; c++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 31) == 0);
            redirect_pc_i = AW'($urandom);
            halt_i        = ($urandom_range(0, 39) == 0);
            start_i       = ($urandom_range(0, 7) == 0);
            @(negedge clk_i);

            vectors++;
            if ({mem_wr_o, mem_data_o} !== 33'h0) begin
                miscompares++;
                $display("FAIL rnd_wr_const: c=%0d got wr=%0b data=%h expected 0", c, mem_wr_o, mem_data_o);
            end
            if (mem_en_o) begin
                vectors++;
                if (!prev_issue_ok || mem_addr_o !== m_issue_pc) begin
                    miscompares++;
                    $display("FAIL rnd_issue: c=%0d got addr=%h legal=%0b expected addr=%h",
                             c, mem_addr_o, prev_issue_ok, m_issue_pc);
                end
                m_issue_pc = m_issue_pc + 1'b1;
            end
            if (prev_redirect) begin
                vectors++;
                if (instr_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_flush: c=%0d got valid=%0b pc=%h expected 0", c, instr_valid_o, instr_pc_o);
                end
            end else if (prev_hold) begin
                vectors++;
                if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, prev_pc, prev_instr}) begin
                    miscompares++;
                    $display("FAIL rnd_hold: c=%0d got v=%0b pc=%h instr=%h expected pc=%h instr=%h",
                             c, instr_valid_o, instr_pc_o, instr_o, prev_pc, prev_instr);
                end
            end
            if (instr_valid_o && instr_ready_i) begin
                vectors++;
                if ({instr_pc_o, instr_o} !== {exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL rnd_stream: c=%0d got pc=%h instr=%h expected pc=%h instr=%h",
                             c, instr_pc_o, instr_o, exp_pc, word(exp_pc));
                end
                exp_pc = exp_pc + 1'b1;
            end
            if (redirect_i) begin
                exp_pc     = redirect_pc_i;
                m_issue_pc = redirect_pc_i;
            end

            prev_issue_ok = (m_state == 1) && !halt_i && !redirect_i;
            prev_hold     = instr_valid_o && !instr_ready_i && !redirect_i;
            prev_redirect = redirect_i;
            prev_pc       = instr_pc_o;
            prev_instr    = instr_o;
            if (m_state == 1) begin
                if (halt_i) m_state = 2;
            end else if (start_i && !halt_i) begin
                m_state = 1;
            end
            tick();
        end
        start_i = 0; halt_i = 0; redirect_i = 0;
    endtask

    initial begin
        mem_data_i = 'z;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
